// File: rtl/rom_loader_uart.sv
// rom_loader_uart: serial boot loader. Receives 8N1 bytes on uart_rx, parses load
// packets (0x55, addr[15:0], len[15:0], data..., [checksum]) into ROM writes, and
// holds the CPU in reset while ROM contents may change (0x5A releases it).
// Optional feature macro: ROM_LOADER_CHECKSUM_EN adds the trailing checksum byte
// and the load_error flag; without it packets carry no checksum.
module rom_loader_uart #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        cpu_rst,
  output logic [15:0] rom_write_addr,
  output logic [7:0]  rom_write_data,
  output logic        rom_write_en,
  output logic        load_busy,
  output logic        load_error,
  output logic        frame_error
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       SYNC_LOAD = 8'h55;
  localparam logic [7:0]       SYNC_RUN  = 8'h5A;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state, rx_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit_idx;
  logic [7:0]       rx_shift;
  logic             rx_sample;
  logic             byte_valid;
  logic             frame_err_pulse;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value,
      // so this chain really is three stages and not one.
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next state and the bit sample point (mid start bit, then every bit time).
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    rx_next   = rx_state;
    rx_sample = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_cnt == CNT_HALF) begin
        rx_sample = 1'b1;
        rx_next   = rx_sync ? RX_IDLE : RX_DATA;  // high here means a glitch
      end
      RX_DATA:  if (rx_cnt == CNT_FULL) begin
        rx_sample = 1'b1;
        if (rx_bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP:  if (rx_cnt == CNT_FULL) begin
        rx_sample = 1'b1;
        rx_next   = RX_IDLE;
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Bit timer, shift register and the one-cycle byte/framing-error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt          <= '0;
      rx_bit_idx      <= '0;
      rx_shift        <= '0;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      if (rx_state == RX_IDLE || rx_sample) rx_cnt <= '0;
      else                                  rx_cnt <= rx_cnt + CNT_W'(1);
      if (rx_state == RX_IDLE) rx_bit_idx <= '0;
      if (rx_sample) begin
        case (rx_state)
          RX_DATA: begin
            rx_shift   <= {rx_sync, rx_shift[7:1]};  // LSB arrives first
            rx_bit_idx <= rx_bit_idx + 3'd1;
          end
          RX_STOP: begin
            byte_valid      <= rx_sync;
            frame_err_pulse <= !rx_sync;
          end
          default: ;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------ parser
  typedef enum logic [2:0] {
    P_IDLE, P_ADDR_HI, P_ADDR_LO, P_LEN_HI, P_LEN_LO, P_DATA
`ifdef ROM_LOADER_CHECKSUM_EN
    , P_CSUM
`endif
  } p_state_t;

  p_state_t    p_state, p_next;
  logic [15:0] byte_cnt;

  // Parser state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p_state <= P_IDLE;
    else        p_state <= p_next;
  end

  // Parser next state; a framing error abandons any packet in progress.
  always_comb begin
    p_next = p_state;
    if (frame_err_pulse) begin
      p_next = P_IDLE;
    end else if (byte_valid) begin
      case (p_state)
        P_IDLE:    if (rx_shift == SYNC_LOAD) p_next = P_ADDR_HI;
        P_ADDR_HI: p_next = P_ADDR_LO;
        P_ADDR_LO: p_next = P_LEN_HI;
        P_LEN_HI:  p_next = P_LEN_LO;
        P_LEN_LO:  p_next = P_DATA;
`ifdef ROM_LOADER_CHECKSUM_EN
        P_DATA:    if (byte_cnt == 16'd1) p_next = P_CSUM;
        P_CSUM:    p_next = P_IDLE;
`else
        P_DATA:    if (byte_cnt == 16'd1) p_next = P_IDLE;
`endif
        default:   p_next = P_IDLE;
      endcase
    end
  end

  assign load_busy = (p_state != P_IDLE);

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       load_error_q;
  assign load_error = load_error_q;

  // Running sum of every byte after 0x55; a good packet sums to zero with its checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum         <= '0;
      load_error_q <= 1'b0;
    end else if (byte_valid) begin
      if (p_state == P_IDLE) begin
        if (rx_shift == SYNC_LOAD) begin
          csum         <= '0;
          load_error_q <= 1'b0;
        end
      end else begin
        csum <= csum + rx_shift;
        if (p_state == P_CSUM && 8'(csum + rx_shift) != 8'h00) load_error_q <= 1'b1;
      end
    end
  end
`else
  assign load_error = 1'b0;
`endif

  // Packet datapath: address/length capture, ROM write strobe, CPU reset and frame flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst        <= 1'b1;
      rom_write_addr <= '0;
      rom_write_data <= '0;
      rom_write_en   <= 1'b0;
      byte_cnt       <= '0;
      frame_error    <= 1'b0;
    end else begin
      rom_write_en <= 1'b0;
      // Address stays on the bus for the strobe cycle, then moves to the next byte.
      if (rom_write_en) rom_write_addr <= rom_write_addr + 16'd1;
      if (frame_err_pulse) frame_error <= 1'b1;
      if (byte_valid) begin
        case (p_state)
          P_IDLE: begin
            if (rx_shift == SYNC_LOAD)                  cpu_rst <= 1'b1;
            else if (rx_shift == SYNC_RUN && !load_error) cpu_rst <= 1'b0;
          end
          P_ADDR_HI: rom_write_addr[15:8] <= rx_shift;
          P_ADDR_LO: rom_write_addr[7:0]  <= rx_shift;
          P_LEN_HI:  byte_cnt[15:8]       <= rx_shift;
          P_LEN_LO:  byte_cnt[7:0]        <= rx_shift;  // 0 wraps to 65536 bytes
          P_DATA: begin
            rom_write_data <= rx_shift;
            rom_write_en   <= 1'b1;
            byte_cnt       <= byte_cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader_uart.sv
// tb_rom_loader_uart: drives serial load packets into rom_loader_uart and compares the
// ROM writes and status outputs against expectations derived from packet contents.
`timescale 1ns/1ps
module tb_rom_loader_uart;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        cpu_rst;
  logic [15:0] rom_write_addr;
  logic [7:0]  rom_write_data;
  logic        rom_write_en;
  logic        load_busy;
  logic        load_error;
  logic        frame_error;

  rom_loader_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .uart_rx        (uart_rx),
    .cpu_rst        (cpu_rst),
    .rom_write_addr (rom_write_addr),
    .rom_write_data (rom_write_data),
    .rom_write_en   (rom_write_en),
    .load_busy      (load_busy),
    .load_error     (load_error),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe cycle is logged; strobe run length is tracked.
  typedef struct packed {logic [15:0] addr; logic [7:0] data;} wr_t;
  wr_t got_q[$];
  int  en_run = 0;
  int  en_run_max = 0;

  always @(negedge clk) begin
    if (rom_write_en) begin
      got_q.push_back({rom_write_addr, rom_write_data});
      en_run++;
      if (en_run > en_run_max) en_run_max = en_run;
    end else begin
      en_run = 0;
    end
  end

  // Reference state, updated from the packet-level rules.
  logic exp_cpu_rst = 1'b1;
  logic exp_load_error = 1'b0;
  logic exp_frame_error = 1'b0;
  logic snap_cpu_rst, snap_busy;   // outputs just before a byte's stop bit
  logic [7:0] pkt_data[$];

  // Send one 8N1 frame LSB first, followed by one idle bit time.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(negedge clk) uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    snap_cpu_rst = cpu_rst;
    snap_busy    = load_busy;
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ":cpu_rst"},     cpu_rst,        1);
    check({tag, ":addr"},        rom_write_addr, 0);
    check({tag, ":data"},        rom_write_data, 0);
    check({tag, ":wr_en"},       rom_write_en,   0);
    check({tag, ":busy"},        load_busy,      0);
    check({tag, ":load_error"},  load_error,     0);
    check({tag, ":frame_error"}, frame_error,    0);
  endtask

  // Send a full packet built from pkt_data; csum_delta != 0 corrupts the checksum.
  task automatic run_packet(input logic [15:0] addr, input logic [7:0] csum_delta,
                            input string tag);
    logic [15:0] len;
    logic [7:0]  sum;
    wr_t         exp_q[$];
    len = 16'(pkt_data.size());
    sum = 8'(addr[15:8] + addr[7:0] + len[15:8] + len[7:0]);
    got_q.delete();
    send_byte(8'h55);
    check({tag, ":cpu_rst_before_55"}, snap_cpu_rst, exp_cpu_rst);
    exp_cpu_rst = 1'b1;
    check({tag, ":cpu_rst_after_55"}, cpu_rst, exp_cpu_rst);
    check({tag, ":busy_after_55"}, load_busy, 1);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < pkt_data.size(); i++) begin
      sum = 8'(sum + pkt_data[i]);
      exp_q.push_back({16'(addr + 16'(i)), pkt_data[i]});
      send_byte(pkt_data[i]);
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    send_byte(8'(8'(-sum) + csum_delta));
    exp_load_error = (csum_delta != 8'h00);
`else
    exp_load_error = 1'b0;
`endif
    check({tag, ":busy_before_last"}, snap_busy, 1);
    check({tag, ":busy_after_last"}, load_busy, 0);
    check({tag, ":write_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s:write%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, ":addr_after"}, rom_write_addr, 16'(exp_q[exp_q.size()-1].addr + 16'd1));
    check({tag, ":data_after"}, rom_write_data, exp_q[exp_q.size()-1].data);
    check({tag, ":load_error"}, load_error, exp_load_error);
    check({tag, ":frame_error"}, frame_error, exp_frame_error);
    check({tag, ":cpu_rst_end"}, cpu_rst, exp_cpu_rst);
  endtask

  task automatic send_release(input string tag);
    send_byte(8'h5A);
    if (!exp_load_error) exp_cpu_rst = 1'b0;
    check({tag, ":cpu_rst_after_5a"}, cpu_rst, exp_cpu_rst);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r_addr;
    logic [7:0]  r_delta;

    // Reset held, then released.
    repeat (5) @(negedge clk);
    check_reset_state("reset_held");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_state("reset_released");

    // Basic packet 55 00 10 00 02 AB CD (76), then release.
    pkt_data = '{8'hAB, 8'hCD};
    run_packet(16'h0010, 8'h00, "basic");
    send_release("basic");

`ifdef ROM_LOADER_CHECKSUM_EN
    // Same packet with a wrong checksum: writes still happen, release refused.
    run_packet(16'h0010, 8'h01, "bad_csum");
    send_release("bad_csum");
    run_packet(16'h0010, 8'h00, "recover");
`endif

    // Address wrap 0xFFFF -> 0x0000; checksum 0xCE is one above the correct 0xCD.
    pkt_data = '{8'h11, 8'h22};
    run_packet(16'hFFFF, 8'h01, "wrap");

    // Randomized packets, some with corrupted checksums, some followed by a release.
    for (int n = 0; n < 6; n++) begin
      r_addr = 16'($urandom);
      r_delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      pkt_data.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) pkt_data.push_back(8'($urandom));
      run_packet(r_addr, r_delta, $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) send_release($sformatf("rand%0d", n));
    end

    // Framing error in the middle of DATA.
    got_q.delete();
    send_byte(8'h55);
    exp_cpu_rst = 1'b1;
    exp_load_error = 1'b0;
    send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    exp_frame_error = 1'b1;
    check("frame:flag", frame_error, 1);
    check("frame:busy", load_busy, 0);
    send_byte(8'h33);
    send_byte(8'h44);
    check("frame:write_count", got_q.size(), 1);
    if (got_q.size() > 0) check("frame:write0", got_q[0], {16'h0020, 8'h11});
    check("frame:busy_after", load_busy, 0);
    check("frame:cpu_rst", cpu_rst, 1);

    // Run the CPU, then 0x55 re-asserts reset; pull rst_n mid-packet.
    send_release("run");
    send_byte(8'h55);
    check("rerun:cpu_rst_before", snap_cpu_rst, 0);
    check("rerun:cpu_rst_after", cpu_rst, 1);
    send_byte(8'h01);
    @(negedge clk) uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    exp_cpu_rst = 1'b1;
    exp_load_error = 1'b0;
    exp_frame_error = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Short low glitch on the line must not produce a byte.
    got_q.delete();
    @(negedge clk) uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch:busy", load_busy, 0);
    check("glitch:writes", got_q.size(), 0);

    // Loader still works after reset and glitch.
    pkt_data = '{8'h5A, 8'h55, 8'hC3};
    run_packet(16'h1234, 8'h00, "final");
    send_release("final");

    check("strobe_width_max", en_run_max, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
